// File: rtl/qspi_pkg.sv
// qspi_pkg: shared constants for the Quad-SPI initiator.
//   - default command bytes for write/read bursts
//   - nibble counts of the CMD and ADDR fields
//   - FSM state encoding (plain localparams so older tools can consume it)
package qspi_pkg;

    localparam logic [7:0] CMD_WR_DEF = 8'h32;
    localparam logic [7:0] CMD_RD_DEF = 8'h6B;

    localparam int CMD_NIBS  = 2;
    localparam int ADDR_NIBS = 8;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_CS_SETUP = 4'd1;
    localparam logic [3:0] ST_CMD      = 4'd2;
    localparam logic [3:0] ST_ADDR     = 4'd3;
    localparam logic [3:0] ST_WDATA    = 4'd4;
    localparam logic [3:0] ST_DUMMY    = 4'd5;
    localparam logic [3:0] ST_RDATA    = 4'd6;
    localparam logic [3:0] ST_CS_HOLD  = 4'd7;
    localparam logic [3:0] ST_CS_IDLE  = 4'd8;

endpackage

// File: rtl/qspi_sck_gen.sv
// qspi_sck_gen: SCK generator for the Quad-SPI initiator (mode 0, idle low).
// Ports:
//   clk100m_i  system clock
//   rst_ni     asynchronous active-low reset
//   en_i       run SCK; when low SCK is forced low and the phase counter cleared
//   sck_o      serial clock
//   rise_o     high in the clk100m cycle at whose end SCK goes high
//   fall_o     high in the clk100m cycle at whose end SCK goes low
module qspi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk100m_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          sck_q;
    logic          tick;

    // SCK toggles every CLK_DIV enabled cycles; the strobes announce the toggle.
    assign tick   = en_i && (cnt_q == CW'(CLK_DIV - 1));
    assign rise_o = tick & ~sck_q;
    assign fall_o = tick &  sck_q;
    assign sck_o  = sck_q;

    always_ff @(posedge clk100m_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else if (tick) begin
            cnt_q <= '0;
            sck_q <= ~sck_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/qspi_master.sv
// qspi_master: Quad-SPI initiator issuing burst writes/reads.
// Frame: CMD(8b) | ADDR(32b) | [DUMMY] | DATA, 4 bits per SCK, MSB nibble first.
// Ports:
//   clk100m, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_rw, cmd_addr, cmd_len       1=read; start address; byte count minus 1
//   wr_data, wr_ack                 write byte source; ack = byte captured
//   rd_data, rd_valid               received byte and its 1-cycle strobe
//   done                            1-cycle pulse when the command has finished
//   qspi_cs, qspi_clk, qspi_d       flash-style bus (CS active low, SCK mode 0)
// Optional: define QSPI_MASTER_STAT_EN to add stat_wr_cnt/stat_rd_cnt
// (completed write/read command counters).
module qspi_master
    import qspi_pkg::*;
#(
    parameter int         CLK_DIV   = 2,
    parameter int         DUMMY_CYC = 4,
    parameter logic [7:0] CMD_WR    = CMD_WR_DEF,
    parameter logic [7:0] CMD_RD    = CMD_RD_DEF
) (
    input  logic        clk100m,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        qspi_cs,
    output logic        qspi_clk,
    inout  wire  [3:0]  qspi_d
`ifdef QSPI_MASTER_STAT_EN
    ,
    output logic [15:0] stat_wr_cnt,
    output logic [15:0] stat_rd_cnt
`endif
);

    logic [3:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  nib_q, nib_d;
    logic [39:0] sh_q, sh_d;
    logic [7:0]  dat_q, dat_d;
    logic [7:0]  bcnt_q, bcnt_d;
    logic        rw_q, rw_d;
    logic        oe_q, oe_d;
    logic        cs_q, cs_d;
    logic        fin_q, fin_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        done_q, done_d;
    logic        wr_ack_c;
    logic        sck_en, sck_rise, sck_fall;
    logic [3:0]  dout;

    assign sck_en = (state_q == ST_CMD)   || (state_q == ST_ADDR)  ||
                    (state_q == ST_WDATA) || (state_q == ST_DUMMY) ||
                    (state_q == ST_RDATA);

    qspi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk100m_i (clk100m),
        .rst_ni    (rst_n),
        .en_i      (sck_en),
        .sck_o     (qspi_clk),
        .rise_o    (sck_rise),
        .fall_o    (sck_fall)
    );

    // The done cycle is already IDLE but must not accept a new command.
    assign cmd_ready = (state_q == ST_IDLE) && !done_q;
    assign wr_ack    = wr_ack_c;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign qspi_cs   = cs_q;

    assign dout   = ((state_q == ST_CS_SETUP) || (state_q == ST_CMD) || (state_q == ST_ADDR))
                    ? sh_q[39:36] : dat_q[7:4];
    assign qspi_d = oe_q ? dout : 4'bz;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nib_d      = nib_q;
        sh_d       = sh_q;
        dat_d      = dat_q;
        bcnt_d     = bcnt_q;
        rw_d       = rw_q;
        oe_d       = oe_q;
        cs_d       = cs_q;
        fin_d      = fin_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        wr_ack_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    // CS falls and the first command nibble is driven together.
                    state_d = ST_CS_SETUP;
                    cs_d    = 1'b0;
                    oe_d    = 1'b1;
                    sh_d    = {(cmd_rw ? CMD_RD : CMD_WR), cmd_addr};
                    rw_d    = cmd_rw;
                    bcnt_d  = cmd_len;
                    cnt_d   = '0;
                    nib_d   = '0;
                    fin_d   = 1'b0;
                end
            end
            ST_CS_SETUP: begin
                if (cnt_q == 16'(CLK_DIV - 1)) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_CMD, ST_ADDR: begin
                if (sck_fall) begin
                    sh_d = {sh_q[35:0], 4'h0};
                    if (state_q == ST_CMD) begin
                        if (nib_q == 3'(CMD_NIBS - 1)) begin
                            state_d = ST_ADDR;
                            nib_d   = '0;
                        end else begin
                            nib_d = nib_q + 3'd1;
                        end
                    end else if (nib_q == 3'(ADDR_NIBS - 1)) begin
                        nib_d = '0;
                        if (rw_q) begin
                            // Release IO at the falling edge ending ADDR (turnaround).
                            oe_d    = 1'b0;
                            cnt_d   = '0;
                            state_d = (DUMMY_CYC == 0) ? ST_RDATA : ST_DUMMY;
                        end else begin
                            state_d  = ST_WDATA;
                            dat_d    = wr_data;
                            wr_ack_c = 1'b1;
                        end
                    end else begin
                        nib_d = nib_q + 3'd1;
                    end
                end
            end
            ST_WDATA: begin
                if (sck_fall) begin
                    if (nib_q == 3'd0) begin
                        nib_d = 3'd1;
                        dat_d = {dat_q[3:0], 4'h0};
                    end else begin
                        nib_d = 3'd0;
                        if (bcnt_q == 8'd0) begin
                            state_d = ST_CS_HOLD;
                            oe_d    = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            bcnt_d   = bcnt_q - 8'd1;
                            dat_d    = wr_data;
                            wr_ack_c = 1'b1;
                        end
                    end
                end
            end
            ST_DUMMY: begin
                if (sck_fall) begin
                    if (cnt_q == 16'(DUMMY_CYC - 1)) begin
                        state_d = ST_RDATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_RDATA: begin
                if (sck_rise && !fin_q) begin
                    if (nib_q == 3'd0) begin
                        nib_d = 3'd1;
                        dat_d = {dat_q[3:0], qspi_d};
                    end else begin
                        nib_d      = 3'd0;
                        rd_data_d  = {dat_q[3:0], qspi_d};
                        rd_valid_d = 1'b1;
                        if (bcnt_q == 8'd0) fin_d = 1'b1;
                        else                bcnt_d = bcnt_q - 8'd1;
                    end
                end
                // Finish the last SCK period before leaving so SCK ends low.
                if (sck_fall && fin_q) begin
                    state_d = ST_CS_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_CS_HOLD: begin
                if (cnt_q == 16'(CLK_DIV - 1)) begin
                    state_d = ST_CS_IDLE;
                    cs_d    = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_CS_IDLE: begin
                if (cnt_q == 16'(2 * CLK_DIV - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = 1'b1;
                oe_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            nib_q      <= '0;
            sh_q       <= '0;
            dat_q      <= '0;
            bcnt_q     <= '0;
            rw_q       <= 1'b0;
            oe_q       <= 1'b0;
            cs_q       <= 1'b1;
            fin_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nib_q      <= nib_d;
            sh_q       <= sh_d;
            dat_q      <= dat_d;
            bcnt_q     <= bcnt_d;
            rw_q       <= rw_d;
            oe_q       <= oe_d;
            cs_q       <= cs_d;
            fin_q      <= fin_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

`ifdef QSPI_MASTER_STAT_EN
    logic [15:0] stat_wr_q, stat_rd_q;

    // Counters move in the same edge that raises done; they wrap naturally.
    always_ff @(posedge clk100m or negedge rst_n) begin
        if (!rst_n) begin
            stat_wr_q <= '0;
            stat_rd_q <= '0;
        end else if (done_d) begin
            if (rw_q) stat_rd_q <= stat_rd_q + 16'd1;
            else      stat_wr_q <= stat_wr_q + 16'd1;
        end
    end

    assign stat_wr_cnt = stat_wr_q;
    assign stat_rd_cnt = stat_rd_q;
`endif

endmodule

// File: tb/tb_qspi_master.sv
// tb_qspi_master: self-checking bench for qspi_master (CLK_DIV=2, DUMMY_CYC=4).
// Contains a behavioural QSPI slave with its own memory and a reference byte
// memory; frames seen on the wire are decoded and compared with what was asked.
module tb_qspi_master;

    localparam int CLK_DIV = 2;
    localparam int DUMMY   = 4;
    localparam int TMO     = 5000;

    logic        clk100m = 1'b0;
    logic        rst_n   = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rw = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ack;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        done;
    logic        qspi_cs;
    logic        qspi_clk;
    wire  [3:0]  qspi_d;
`ifdef QSPI_MASTER_STAT_EN
    logic [15:0] stat_wr_cnt, stat_rd_cnt;
`endif

    qspi_master #(.CLK_DIV(CLK_DIV), .DUMMY_CYC(DUMMY)) dut (
        .clk100m   (clk100m),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .qspi_cs   (qspi_cs),
        .qspi_clk  (qspi_clk),
        .qspi_d    (qspi_d)
`ifdef QSPI_MASTER_STAT_EN
        ,
        .stat_wr_cnt (stat_wr_cnt),
        .stat_rd_cnt (stat_rd_cnt)
`endif
    );

    initial forever #5 clk100m = ~clk100m;

    // Undriven IO reads as 4'hF.
    pullup pu0 (qspi_d[0]);
    pullup pu1 (qspi_d[1]);
    pullup pu2 (qspi_d[2]);
    pullup pu3 (qspi_d[3]);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // ---------------- reference memory model ----------------
    logic [7:0] ref_mem [bit [31:0]];
    function automatic logic [7:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    // ---------------- behavioural slave ----------------
    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] addr;
        int          rises;
    } frame_t;

    frame_t      frames[$];
    logic [7:0]  s_mem [bit [31:0]];
    logic [3:0]  s_nibs[$];
    int          s_rises = 0;
    bit          s_rd = 0;
    logic [31:0] s_addr = '0;
    logic [3:0]  s_dout = '0;
    bit          s_oe = 0;
    int          s_idx;
    logic [7:0]  s_byte;
    frame_t      s_fr;

    assign qspi_d = s_oe ? s_dout : 4'bz;

    function automatic logic [7:0] s_read(input logic [31:0] a);
        return s_mem.exists(a) ? s_mem[a] : init_byte(a);
    endfunction

    always @(negedge qspi_cs) begin
        s_rises = 0;
        s_nibs.delete();
        s_rd   = 0;
        s_addr = '0;
    end

    always @(posedge qspi_clk) begin
        if (!qspi_cs) begin
            s_rises++;
            if (s_rd && s_rises > 10) begin
                if (s_rises <= 10 + DUMMY) chk("dummy_io_z", {28'd0, qspi_d}, 32'hF);
            end else begin
                s_nibs.push_back(qspi_d);
            end
            if (s_rises == 2) s_rd = ({s_nibs[0], s_nibs[1]} == 8'h6B);
            if (s_rises == 10)
                for (int i = 2; i < 10; i++) s_addr = {s_addr[27:0], s_nibs[i]};
        end
    end

    always @(negedge qspi_clk) begin
        if (!qspi_cs && s_rd && s_rises >= 10 + DUMMY) begin
            s_idx  = s_rises - (10 + DUMMY);
            s_byte = s_read(s_addr + 32'(s_idx / 2));
            s_dout = (s_idx % 2 == 1) ? s_byte[3:0] : s_byte[7:4];
            s_oe   = 1;
        end
    end

    always @(posedge qspi_cs) begin
        s_oe = 0;
        s_fr.cmd   = (s_nibs.size() >= 2) ? {s_nibs[0], s_nibs[1]} : 8'h00;
        s_fr.addr  = s_addr;
        s_fr.rises = s_rises;
        frames.push_back(s_fr);
        if (s_fr.cmd == 8'h32 && s_nibs.size() >= 12)
            for (int k = 0; 11 + 2 * k < s_nibs.size(); k++)
                s_mem[s_addr + 32'(k)] = {s_nibs[10 + 2 * k], s_nibs[11 + 2 * k]};
    end

    // ---------------- monitors ----------------
    int cyc = 0;
    int done_total = 0;
    int hi_cnt = 0;
    int last_desel = 0;
    always @(posedge clk100m) begin
        cyc++;
        if (done) done_total++;
        if (qspi_cs) hi_cnt++;
    end
    always @(negedge qspi_cs) begin
        last_desel = hi_cnt;
        hi_cnt = 0;
    end

    // ---------------- command driver ----------------
    logic [7:0]  wbuf [256];
    bit          nx_rw;
    logic [31:0] nx_addr;
    logic [7:0]  nx_len;
    int          done_cyc = 0;
    int          acc_cyc = 0;
    int          n_wr = 0;
    int          n_rd = 0;

    task automatic do_cmd(input bit rw, input logic [31:0] addr, input logic [7:0] len,
                          input int exp_n, input int exp_rises, input bit hold);
        int n, acks, dn, bi;
        bit pend;
        logic [7:0] rds[$];
        frame_t f;
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_len   = len;
        wr_data   = wbuf[0];
        n = 0;
        while (!cmd_ready && n < TMO) begin
            @(posedge clk100m); #1; n++;
        end
        chk("ready_wait", {31'd0, cmd_ready}, 1);
        @(posedge clk100m); #1;
        acc_cyc = cyc;
        chk("accepted", {31'd0, cmd_ready}, 0);
        if (hold) begin
            cmd_rw = nx_rw; cmd_addr = nx_addr; cmd_len = nx_len;
        end else begin
            cmd_valid = 1'b0;
        end
        acks = 0; dn = 0; bi = 1; pend = 0;
        for (n = 0; n < TMO && dn == 0; n++) begin
            @(posedge clk100m); #1;
            if (pend) begin
                wr_data = (bi < 256) ? wbuf[bi] : 8'h00;
                bi++;
                pend = 0;
            end
            if (wr_ack) begin acks++; pend = 1; end
            if (rd_valid) rds.push_back(rd_data);
            if (done) begin
                dn++;
                done_cyc = cyc;
                chk("ready_low_in_done", {31'd0, cmd_ready}, 0);
            end
        end
        chk("done_seen", dn, 1);
        @(posedge clk100m); #1;
        chk("ready_after_done", {31'd0, cmd_ready}, 1);
        chk("done_single", {31'd0, done}, 0);
        if (rw) begin
            n_rd++;
            chk("rd_count", rds.size(), exp_n);
            for (int i = 0; i < rds.size() && i <= int'(len); i++)
                chk($sformatf("rd_byte[%0d]", i), {24'd0, rds[i]}, {24'd0, ref_read(addr + 32'(i))});
        end else begin
            n_wr++;
            chk("ack_count", acks, exp_n);
            for (int i = 0; i <= int'(len); i++) begin
                ref_mem[addr + 32'(i)] = wbuf[i];
                chk($sformatf("mem_byte[%0d]", i), {24'd0, s_read(addr + 32'(i))}, {24'd0, wbuf[i]});
            end
        end
        chk("frame_seen", frames.size(), 1);
        if (frames.size() > 0) begin
            f = frames.pop_front();
            chk("frame_cmd", {24'd0, f.cmd}, rw ? 32'h6B : 32'h32);
            chk("frame_addr", f.addr, addr);
            chk("frame_sck", f.rises, exp_rises);
        end
        $display("txn %s addr=%08h len=%0d acks=%0d rds=%0d", rw ? "RD" : "WR", addr, len, acks, rds.size());
    endtask

    function automatic int rises_of(input bit rw, input logic [7:0] len);
        return 10 + (rw ? DUMMY : 0) + 2 * (int'(len) + 1);
    endfunction

    // ---------------- test ----------------
    typedef struct {
        bit          rw;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [7:0]  b0;
        logic [7:0]  step;
        int          exp_n;
        int          exp_rises;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int d0, a;
        vecs[0] = '{0, 32'h0000_0010, 8'd0, 8'hA5, 8'h00, 1, 12};
        vecs[1] = '{0, 32'h0000_0000, 8'd3, 8'h11, 8'h11, 4, 18};
        vecs[2] = '{1, 32'h0000_0000, 8'd3, 8'h00, 8'h00, 4, 22};
        vecs[3] = '{1, 32'h0000_0010, 8'd0, 8'h00, 8'h00, 1, 16};
        vecs[4] = '{0, 32'hFFFF_FFFE, 8'd2, 8'h3C, 8'h47, 3, 16};
        vecs[5] = '{1, 32'hFFFF_FFFE, 8'd2, 8'h00, 8'h00, 3, 20};

        repeat (5) @(posedge clk100m);
        #1;
        chk("rst_cs", {31'd0, qspi_cs}, 1);
        chk("rst_clk", {31'd0, qspi_clk}, 0);
        chk("rst_ready", {31'd0, cmd_ready}, 1);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_rd_data", {24'd0, rd_data}, 0);
        chk("rst_io_z", {28'd0, qspi_d}, 32'hF);
        rst_n = 1'b1;
        repeat (3) @(posedge clk100m);
        #1;
        chk("idle_ready", {31'd0, cmd_ready}, 1);
        chk("idle_ack", {31'd0, wr_ack}, 0);
        chk("idle_rd_valid", {31'd0, rd_valid}, 0);
        frames.delete();

        // table-driven vectors
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 256; i++) wbuf[i] = vecs[v].b0 + 8'(i) * vecs[v].step;
            do_cmd(vecs[v].rw, vecs[v].addr, vecs[v].len, vecs[v].exp_n, vecs[v].exp_rises, 0);
        end

        // randomized commands on a small window so reads revisit writes
        for (int r = 0; r < 10; r++) begin
            bit rw;
            logic [7:0] len;
            logic [31:0] addr;
            rw   = 1'($urandom_range(0, 1));
            len  = 8'($urandom_range(0, 7));
            addr = 32'h0000_0200 + 32'($urandom_range(0, 24));
            for (int i = 0; i < 256; i++) wbuf[i] = 8'($urandom);
            do_cmd(rw, addr, len, int'(len) + 1, rises_of(rw, len), 0);
        end

        // longest burst: 256 bytes, no wrap of the byte counter
        for (int i = 0; i < 256; i++) wbuf[i] = 8'(i) ^ 8'hC3;
        do_cmd(0, 32'h0000_1000, 8'd255, 256, rises_of(0, 8'd255), 0);
        do_cmd(1, 32'h0000_10FE, 8'd1, 2, rises_of(1, 8'd1), 0);

        // reset in the middle of ADDR (nibble 5)
        d0 = done_total;
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 32'h0000_0300; cmd_len = 8'd3; wr_data = 8'h99;
        @(posedge clk100m); #1;
        cmd_valid = 1'b0;
        a = 0;
        while (s_rises < 7 && a < TMO) begin
            @(posedge clk100m); #1; a++;
        end
        chk("reached_addr5", s_rises, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cs", {31'd0, qspi_cs}, 1);
        chk("mid_rst_clk", {31'd0, qspi_clk}, 0);
        chk("mid_rst_io_z", {28'd0, qspi_d}, 32'hF);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 1);
        repeat (3) @(posedge clk100m);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk100m);
        #1;
        chk("no_done_on_reset", done_total, d0);
        frames.delete();
        n_wr = 0; n_rd = 0;
        $display("txn RESET mid-frame at addr nibble 5");
        for (int i = 0; i < 256; i++) wbuf[i] = 8'h5E - 8'(i);
        do_cmd(0, 32'h0000_0300, 8'd3, 4, rises_of(0, 8'd3), 0);

        // back-to-back: cmd_valid held through the done cycle
        for (int i = 0; i < 256; i++) wbuf[i] = 8'h71 + 8'(i);
        nx_rw = 1'b1; nx_addr = 32'h0000_0040; nx_len = 8'd1;
        do_cmd(0, 32'h0000_0040, 8'd1, 2, rises_of(0, 8'd1), 1);
        d0 = done_cyc;
        do_cmd(1, 32'h0000_0040, 8'd1, 2, rises_of(1, 8'd1), 0);
        chk("b2b_accept_cycle", acc_cyc, d0 + 2);
        chk("b2b_deselect_min", {31'd0, (last_desel >= 2 * CLK_DIV) ? 1'b1 : 1'b0}, 1);

`ifdef QSPI_MASTER_STAT_EN
        chk("stat_wr_cnt", {16'd0, stat_wr_cnt}, n_wr);
        chk("stat_rd_cnt", {16'd0, stat_rd_cnt}, n_rd);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
